// File: rtl/sram_like_arbiter_if.sv
// Bundle of sram-like port signals (req/addr_ok/data_ok handshake).
// NUM_CH lanes share one rdata bus; the downstream side uses NUM_CH = 1.
interface sram_like_arbiter_if #(
   parameter int unsigned NUM_CH = 1,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [NUM_CH-1:0]          req;
   logic [NUM_CH-1:0]          wr;
   logic [2*NUM_CH-1:0]        size;
   logic [NUM_CH*DATA_W/8-1:0] wstrb;
   logic [NUM_CH*ADDR_W-1:0]   addr;
   logic [NUM_CH*DATA_W-1:0]   wdata;
   logic [NUM_CH-1:0]          addr_ok;
   logic [NUM_CH-1:0]          data_ok;
   logic [DATA_W-1:0]          rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one downstream sram-like port among NUM_CH upstream masters.
// Address phases are arbitrated; accepted ids go into an in-order FIFO so each
// downstream response is routed back to its owner.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration, otherwise
// fixed priority with the highest channel index winning.
module sram_like_arbiter #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned OUT_DEPTH = 4,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   sram_like_arbiter_if.slave           up,
   sram_like_arbiter_if.master          dn,
   output logic [$clog2(OUT_DEPTH):0]   outstanding,
   output logic                         err_unexp
);
   localparam int unsigned IdW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PtrW = $clog2(OUT_DEPTH);
   localparam int unsigned StrW = DATA_W / 8;

   typedef enum logic {StIdle, StHold} state_e;

   state_e               state_q;
   logic [IdW-1:0]       gnt_q;
   logic [IdW-1:0]       arb_id;
   logic [IdW-1:0]       grant;
   logic                 any_req;
   logic                 m_req;
   logic                 accept;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;

   logic [IdW-1:0]       mem [OUT_DEPTH];
   logic [PtrW-1:0]      wr_ptr_q;
   logic [PtrW-1:0]      rd_ptr_q;
   logic [PtrW:0]        count_q;
   logic                 err_q;
   logic [IdW-1:0]       head;

`ifdef SRAM_ARB_RR_EN
   logic [IdW-1:0]       rr_q;
   logic                 found;

   // Round-robin search starting at the pointer.
   always_comb begin
      arb_id = rr_q;
      found  = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (!found && up.req[(int'(rr_q) + i) % int'(NUM_CH)]) begin
            found  = 1'b1;
            arb_id = IdW'((int'(rr_q) + i) % int'(NUM_CH));
         end
      end
   end
`else
   // Fixed priority: later iterations overwrite, so the highest index wins.
   always_comb begin
      arb_id = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (up.req[i]) begin
            arb_id = IdW'(i);
         end
      end
   end
`endif

   assign any_req = |up.req;
   assign full    = (count_q == (PtrW + 1)'(OUT_DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem[rd_ptr_q];

   // While locked the address phase is frozen to the registered owner.
   assign grant   = (state_q == StHold) ? gnt_q : arb_id;
   assign m_req   = (state_q == StHold) ? 1'b1 : (any_req & ~full);
   assign accept  = m_req & dn.addr_ok[0];
   assign push    = accept;
   assign pop     = dn.data_ok[0] & ~empty;

   assign dn.req      = m_req;
   assign dn.wr       = up.wr[grant];
   assign dn.size     = up.size[int'(grant)*2 +: 2];
   assign dn.wstrb    = up.wstrb[int'(grant)*int'(StrW) +: StrW];
   assign dn.addr     = up.addr[int'(grant)*int'(ADDR_W) +: ADDR_W];
   assign dn.wdata    = up.wdata[int'(grant)*int'(DATA_W) +: DATA_W];
   assign up.rdata    = pop ? dn.rdata : '0;
   assign outstanding = count_q;
   assign err_unexp   = err_q;

   // One-hot accept to the granted channel and response to the FIFO head.
   always_comb begin
      up.addr_ok = '0;
      up.data_ok = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (accept && grant == IdW'(i)) begin
            up.addr_ok[i] = 1'b1;
         end
         if (pop && head == IdW'(i)) begin
            up.data_ok[i] = 1'b1;
         end
      end
   end

   // Lock FSM: capture the grant when the downstream stalls the address phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         gnt_q   <= '0;
`ifdef SRAM_ARB_RR_EN
         rr_q    <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (m_req && !dn.addr_ok[0]) begin
                  state_q <= StHold;
                  gnt_q   <= arb_id;
               end
            end
            StHold: begin
               if (dn.addr_ok[0]) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
`ifdef SRAM_ARB_RR_EN
         if (accept) begin
            rr_q <= (int'(grant) == int'(NUM_CH) - 1) ? '0 : grant + 1'b1;
         end
`endif
      end
   end

   // In-order id FIFO plus sticky unexpected-response flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr_q] <= grant;
            wr_ptr_q      <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
         if (dn.data_ok[0] && empty) begin
            err_q <= 1'b1;
         end
      end
   end
endmodule
